// File: rtl/tx_request_issuer_pkg.sv
// Shared types and widths for the TX request issuer.
package tx_issue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } tx_issue_state_t;

  localparam int C_CHNL_IDX_W  = 4;
  localparam int C_ISSUE_CNT_W = 16;

endpackage

// File: rtl/tx_request_issuer_if.sv
// Descriptor handshake between the request issuer (master) and the TX engine (slave).
interface tx_request_issuer_if
  import tx_issue_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_LEN_WIDTH  = 10
) ();

  logic                    TX_VALID;
  logic                    TX_READY;
  logic [C_CHNL_IDX_W-1:0] TX_CHNL;
  logic [C_ADDR_WIDTH-1:0] TX_ADDR;
  logic [C_LEN_WIDTH-1:0]  TX_LEN;

  modport master (
    output TX_VALID,
    output TX_CHNL,
    output TX_ADDR,
    output TX_LEN,
    input  TX_READY
  );

  modport slave (
    input  TX_VALID,
    input  TX_CHNL,
    input  TX_ADDR,
    input  TX_LEN,
    output TX_READY
  );

endinterface

// File: rtl/tx_request_issuer.sv
// Takes a grant from the round-robin TX channel selector, captures that channel's
// descriptor, issues it to the TX engine, acknowledges the channel and then waits
// for the selector to drop its request. Tracks a release timeout and an issue count.
module tx_request_issuer
  import tx_issue_pkg::*;
#(
  parameter int C_NUM_CHNL    = 12,
  parameter int C_ADDR_WIDTH  = 64,
  parameter int C_LEN_WIDTH   = 10,
  parameter int C_REL_TIMEOUT = 256
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               SEL_REQ,
  input  logic [C_CHNL_IDX_W-1:0]            SEL_CHNL,
  input  logic [C_NUM_CHNL*C_ADDR_WIDTH-1:0] CHNL_ADDR,
  input  logic [C_NUM_CHNL*C_LEN_WIDTH-1:0]  CHNL_LEN,
  output logic [C_NUM_CHNL-1:0]              CHNL_ACK,
  tx_request_issuer_if.master                tx,
  output logic                               ERR,
  output logic [C_ISSUE_CNT_W-1:0]           ISSUE_CNT
);

  localparam int C_TIMER_W = $clog2(C_REL_TIMEOUT);
  localparam logic [C_TIMER_W-1:0] TIMER_LAST = C_TIMER_W'(C_REL_TIMEOUT - 1);

  tx_issue_state_t state, stateNext;

  logic                     txValid,  txValidNext;
  logic [C_CHNL_IDX_W-1:0]  txChnl,   txChnlNext;
  logic [C_ADDR_WIDTH-1:0]  txAddr,   txAddrNext;
  logic [C_LEN_WIDTH-1:0]   txLen,    txLenNext;
  logic [C_NUM_CHNL-1:0]    chnlAck,  chnlAckNext;
  logic                     err,      errNext;
  logic [C_ISSUE_CNT_W-1:0] issueCnt, issueCntNext;
  logic [C_TIMER_W-1:0]     relTimer, relTimerNext;

  logic                     selHit;
  logic [C_ADDR_WIDTH-1:0]  selAddr;
  logic [C_LEN_WIDTH-1:0]   selLen;
  logic [C_NUM_CHNL-1:0]    grantOneHot;

  // Resolve the selector index to its descriptor slice; indices past the last channel never hit.
  always_comb begin
    selHit  = 1'b0;
    selAddr = '0;
    selLen  = '0;
    for (int unsigned i = 0; i < C_NUM_CHNL; i++) begin
      if (SEL_CHNL == C_CHNL_IDX_W'(i)) begin
        selHit  = 1'b1;
        selAddr = CHNL_ADDR[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        selLen  = CHNL_LEN[i*C_LEN_WIDTH +: C_LEN_WIDTH];
      end
    end
  end

  // One-hot acknowledge pattern for the channel held in the descriptor.
  always_comb begin
    grantOneHot = '0;
    for (int unsigned i = 0; i < C_NUM_CHNL; i++) begin
      if (txChnl == C_CHNL_IDX_W'(i)) begin
        grantOneHot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode for the capture/issue/release sequence.
  always_comb begin
    stateNext    = state;
    txValidNext  = txValid;
    txChnlNext   = txChnl;
    txAddrNext   = txAddr;
    txLenNext    = txLen;
    chnlAckNext  = '0;
    errNext      = err;
    issueCntNext = issueCnt;
    relTimerNext = relTimer;

    unique case (state)
      IDLE: begin
        if (SEL_REQ && selHit) begin
          stateNext   = ISSUE;
          txValidNext = 1'b1;
          txChnlNext  = SEL_CHNL;
          txAddrNext  = selAddr;
          txLenNext   = selLen;
        end
      end

      ISSUE: begin
        // TX_VALID is always high in ISSUE, so TX_READY alone completes the handshake.
        if (tx.TX_READY) begin
          stateNext    = RELEASE;
          txValidNext  = 1'b0;
          chnlAckNext  = grantOneHot;
          issueCntNext = issueCnt + C_ISSUE_CNT_W'(1);
          relTimerNext = '0;
        end
      end

      RELEASE: begin
        if (!SEL_REQ) begin
          stateNext    = IDLE;
          relTimerNext = '0;
        end else if (relTimer == TIMER_LAST) begin
          errNext = 1'b1;
        end else begin
          relTimerNext = relTimer + C_TIMER_W'(1);
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Registered descriptor, acknowledge, error, counter and release timer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      txValid  <= 1'b0;
      txChnl   <= '0;
      txAddr   <= '0;
      txLen    <= '0;
      chnlAck  <= '0;
      err      <= 1'b0;
      issueCnt <= '0;
      relTimer <= '0;
    end else begin
      txValid  <= txValidNext;
      txChnl   <= txChnlNext;
      txAddr   <= txAddrNext;
      txLen    <= txLenNext;
      chnlAck  <= chnlAckNext;
      err      <= errNext;
      issueCnt <= issueCntNext;
      relTimer <= relTimerNext;
    end
  end

  assign tx.TX_VALID = txValid;
  assign tx.TX_CHNL  = txChnl;
  assign tx.TX_ADDR  = txAddr;
  assign tx.TX_LEN   = txLen;
  assign CHNL_ACK    = chnlAck;
  assign ERR         = err;
  assign ISSUE_CNT   = issueCnt;

endmodule

// File: tb/tb_tx_request_issuer.sv
// Scoreboard bench for tx_request_issuer: a selector-like driver pushes expected
// descriptors, a monitor pops and checks them as the DUT presents them.
module tb_tx_request_issuer;
  import tx_issue_pkg::*;

  localparam int N  = 12;
  localparam int AW = 64;
  localparam int LW = 10;
  localparam int TO = 256;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          SEL_REQ;
  logic [3:0]    SEL_CHNL;
  logic [N*AW-1:0] CHNL_ADDR;
  logic [N*LW-1:0] CHNL_LEN;
  logic [N-1:0]  CHNL_ACK;
  logic          ERR;
  logic [15:0]   ISSUE_CNT;

  tx_request_issuer_if #(.C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) txBus ();

  tx_request_issuer #(
    .C_NUM_CHNL   (N),
    .C_ADDR_WIDTH (AW),
    .C_LEN_WIDTH  (LW),
    .C_REL_TIMEOUT(TO)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .SEL_REQ  (SEL_REQ),
    .SEL_CHNL (SEL_CHNL),
    .CHNL_ADDR(CHNL_ADDR),
    .CHNL_LEN (CHNL_LEN),
    .CHNL_ACK (CHNL_ACK),
    .tx       (txBus.master),
    .ERR      (ERR),
    .ISSUE_CNT(ISSUE_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]    chnl;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } desc_t;

  desc_t       descQ[$];
  int          nCompared = 0;
  int          nMismatch = 0;
  logic [15:0] expCnt = '0;
  bit          errSticky = 1'b0;
  int          readyMode = 1;   // 0 random, 1 always ready, 2 never ready
  bit          ackPending = 1'b0;
  logic [N-1:0] ackExp;
  desc_t       mon;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      CHNL_ADDR[i*AW +: AW] = {$urandom, $urandom};
      CHNL_LEN[i*LW +: LW]  = LW'($urandom);
    end
  endtask

  // Ready generator: changes just after the active edge.
  initial begin
    txBus.TX_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (readyMode)
        0:       txBus.TX_READY = ($urandom_range(0, 2) != 0);
        1:       txBus.TX_READY = 1'b1;
        default: txBus.TX_READY = 1'b0;
      endcase
    end
  end

  // Monitor: checks presented descriptors against the scoreboard and the following ACK.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        ackPending = 1'b0;
      end else begin
        if (ackPending) begin
          check("ack_onehot", 64'(CHNL_ACK), 64'(ackExp));
          check("valid_drop", 64'(txBus.TX_VALID), 64'd0);
          expCnt++;
          check("issue_cnt", 64'(ISSUE_CNT), 64'(expCnt));
          ackPending = 1'b0;
        end else begin
          check("ack_idle", 64'(CHNL_ACK), 64'd0);
        end
        if (txBus.TX_VALID) begin
          if (descQ.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL unexpected_valid: got chnl %0d with no descriptor expected at %0t",
                     txBus.TX_CHNL, $time);
          end else begin
            mon = descQ[0];
            check("tx_chnl", 64'(txBus.TX_CHNL), 64'(mon.chnl));
            check("tx_addr", txBus.TX_ADDR, mon.addr);
            check("tx_len", 64'(txBus.TX_LEN), 64'(mon.len));
            if (txBus.TX_READY) begin
              ackExp = '0;
              ackExp[mon.chnl] = 1'b1;
              void'(descQ.pop_front());
              ackPending = 1'b1;
            end
          end
        end
      end
    end
  end

  // One selector grant: request, optional stall, wait for ACK, hold, release.
  task automatic grant(input logic [3:0] c, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input int hold, input int stall);
    desc_t d;
    bit    ok;
    bit    acked;
    int    idx;
    idx = int'(c);
    @(negedge CLK);
    ok = (idx < N);
    if (ok) begin
      CHNL_ADDR[idx*AW +: AW] = a;
      CHNL_LEN[idx*LW +: LW]  = l;
      d.chnl = c;
      d.addr = a;
      d.len  = l;
      descQ.push_back(d);
    end
    SEL_CHNL = c;
    SEL_REQ  = 1'b1;
    @(negedge CLK);
    scramble();
    check("valid_latency", 64'(txBus.TX_VALID), 64'(ok));
    if (!ok) begin
      @(negedge CLK);
      check("invalid_ignored", 64'(txBus.TX_VALID), 64'd0);
      SEL_REQ = 1'b0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      CHNL_ADDR[idx*AW +: AW] = {$urandom, $urandom};
      SEL_REQ = (i % 2 == 0);
      check("stall_valid", 64'(txBus.TX_VALID), 64'd1);
    end
    SEL_REQ = 1'b1;
    if (stall > 0) readyMode = 1;
    acked = 1'b0;
    for (int i = 0; i < 200 && !acked; i++) begin
      if (CHNL_ACK != '0) acked = 1'b1;
      else @(negedge CLK);
    end
    if (!acked) begin
      nCompared++;
      nMismatch++;
      $display("FAIL ack_timeout: no ACK for chnl %0d within 200 cycles", c);
      SEL_REQ = 1'b0;
      return;
    end
    for (int k = 0; k <= hold; k++) begin
      if (k >= TO) errSticky = 1'b1;
      check("err_flag", 64'(ERR), 64'(errSticky));
      if (k < hold) begin
        @(negedge CLK);
        SEL_CHNL = 4'($urandom_range(0, 15));
      end
    end
    SEL_REQ = 1'b0;
  endtask

  initial begin
    RST_N = 1'b1;
    SEL_REQ = 1'b0;
    SEL_CHNL = '0;
    CHNL_ADDR = '0;
    CHNL_LEN = '0;
    #1 RST_N = 1'b0;
    #2;
    check("rst_valid", 64'(txBus.TX_VALID), 64'd0);
    check("rst_ack", 64'(CHNL_ACK), 64'd0);
    check("rst_chnl", 64'(txBus.TX_CHNL), 64'd0);
    check("rst_addr", txBus.TX_ADDR, 64'd0);
    check("rst_len", 64'(txBus.TX_LEN), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_cnt", 64'(ISSUE_CNT), 64'd0);
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    grant(4'd3, 64'h1000, 10'd32, 0, 0);
    readyMode = 2;
    repeat (2) @(negedge CLK);
    grant(4'd3, 64'h1000, 10'd32, 0, 5);
    grant(4'd2, 64'h2222_0000, 10'd7, 0, 0);
    grant(4'd7, 64'h7777_0000, 10'd100, 0, 0);
    grant(4'd13, 64'hDEAD, 10'd5, 0, 0);
    grant(4'd0, 64'hABCD_0000_1234, 10'd0, 1, 0);
    grant(4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 10'h3FF, 2, 0);

    readyMode = 0;
    for (int i = 0; i < 60; i++) begin
      grant(4'($urandom_range(0, 15)), {$urandom, $urandom}, LW'($urandom),
            $urandom_range(0, 4), 0);
    end
    check("err_clear", 64'(ERR), 64'd0);

    readyMode = 1;
    grant(4'd5, 64'h5555, 10'd55, 300, 0);
    grant(4'd9, 64'h9999, 10'd99, 0, 0);
    check("err_sticky", 64'(ERR), 64'd1);

    readyMode = 2;
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    CHNL_ADDR[4*AW +: AW] = 64'h4444;
    CHNL_LEN[4*LW +: LW]  = 10'd44;
    descQ.push_back('{chnl: 4'd4, addr: 64'h4444, len: 10'd44});
    SEL_CHNL = 4'd4;
    SEL_REQ  = 1'b1;
    @(negedge CLK);
    check("pre_reset_valid", 64'(txBus.TX_VALID), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 64'(txBus.TX_VALID), 64'd0);
    check("mid_rst_ack", 64'(CHNL_ACK), 64'd0);
    check("mid_rst_cnt", 64'(ISSUE_CNT), 64'd0);
    check("mid_rst_err", 64'(ERR), 64'd0);
    descQ.delete();
    expCnt = '0;
    errSticky = 1'b0;
    SEL_REQ = 1'b0;
    readyMode = 1;
    @(negedge CLK);
    #1 RST_N = 1'b1;
    grant(4'd6, 64'h6666, 10'd66, 0, 0);
    check("post_rst_err", 64'(ERR), 64'd0);

    repeat (3) @(negedge CLK);
    check("queue_drained", 64'(descQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
